// File: rtl/rotor_stepper.sv
// Keypress front end and rotor-position controller for the Enigma datapath.
// It takes one letter per handshake, steps three rotor positions odometer-style,
// including the notch double-step, and hands the letter plus the post-step
// offsets to the rotor chain. In set mode it loads rotor positions instead.
module rotor_stepper #(
  parameter int NOTCH1 = 16,
  parameter int NOTCH2 = 4
) (
  input  logic       signal,
  input  logic       reset,
  input  logic       mode,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [4:0] key_in,
  input  logic       set_we,
  input  logic [1:0] set_sel,
  input  logic [4:0] set_val,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] key_out,
  output logic [5:0] counter1,
  output logic [5:0] counter2,
  output logic [5:0] counter3,
  output logic       key_err
);

  typedef enum logic [1:0] {IDLE, STEP, ISSUE} state_t;

  state_t     state;
  logic [4:0] pos1, pos2, pos3;

  // Advance one rotor position, wrapping 25 -> 0.
  function automatic logic [4:0] inc26(input logic [4:0] p);
    return (p == 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  logic key_fire, key_ok, set_fire, val_ok;
  logic d2, s2, s3;

  // Handshake qualifiers and the stepping decision on pre-step positions.
  always_comb begin
    key_fire = key_valid & key_ready;
    key_ok   = (key_in >= 5'd1) && (key_in <= 5'd26);
    set_fire = (state == IDLE) & mode & set_we;
    val_ok   = (set_val <= 5'd25);
    d2       = (pos2 == 5'(NOTCH2));
    s2       = (pos1 == 5'(NOTCH1)) | d2;
    s3       = d2;
  end

  // Offsets are the zero-extended positions; they only move in STEP or on a set write.
  assign counter1 = {1'b0, pos1};
  assign counter2 = {1'b0, pos2};
  assign counter3 = {1'b0, pos3};

  // Control FSM, rotor positions and all registered outputs.
  always_ff @(posedge signal or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pos1      <= '0;
      pos2      <= '0;
      pos3      <= '0;
      key_out   <= '0;
      out_valid <= 1'b0;
      key_ready <= 1'b1;
      key_err   <= 1'b0;
    end else begin
      key_err <= 1'b0;
      case (state)
        IDLE: begin
          // A set write and a dropped key may coincide: both take effect.
          if (set_fire && set_sel != 2'd0) begin
            if (val_ok) begin
              case (set_sel)
                2'd1:    pos1 <= set_val;
                2'd2:    pos2 <= set_val;
                default: pos3 <= set_val;
              endcase
            end else begin
              key_err <= 1'b1;
            end
          end
          if (key_fire) begin
            if (!mode && key_ok) begin
              key_out   <= key_in;
              key_ready <= 1'b0;
              state     <= STEP;
            end else begin
              key_err <= 1'b1;
            end
          end
        end
        STEP: begin
          pos1      <= inc26(pos1);
          if (s2) pos2 <= inc26(pos2);
          if (s3) pos3 <= inc26(pos3);
          out_valid <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            key_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          key_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
